// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side is the sequencer; the slave side is the datapath it steers.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // ID/EX operand and destination information
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_re;
    logic             id_rs2_re;
    logic [4:0]       ex_rd_addr;
    logic             ex_reg_enable;
    logic             ex_mem_re;
    logic             ex_branch_taken;

    // Data-bus handshake seen by the MEM stage
    logic             mem_req;
    logic             mem_ready;

    logic             perf_clr;

    // Stall/flush controls for the PC and pipeline register banks
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_flush;
    logic             pc_redirect;
    logic             bus_err;
    logic [CNT_W-1:0] stall_count;

    modport master (
        input  id_rs1_addr, id_rs2_addr, id_rs1_re, id_rs2_re,
        input  ex_rd_addr, ex_reg_enable, ex_mem_re, ex_branch_taken,
        input  mem_req, mem_ready, perf_clr,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_stall, mem_wb_flush, pc_redirect, bus_err, stall_count
    );

    modport slave (
        output id_rs1_addr, id_rs2_addr, id_rs1_re, id_rs2_re,
        output ex_rd_addr, ex_reg_enable, ex_mem_re, ex_branch_taken,
        output mem_req, mem_ready, perf_clr,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_stall, mem_wb_flush, pc_redirect, bus_err, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use interlocks, taken-branch flushes, data-bus wait states with a
// timeout, and counts the cycles in which the PC is held.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.master bus
);

    typedef enum logic [1:0] {StRun, StMemWait, StBusErr} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic bus_hold;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
    logic pc_redirect;
    logic bus_err;

    // Load in EX whose destination is a source of the instruction in ID.
    always_comb begin
        load_use = bus.ex_mem_re & bus.ex_reg_enable & (bus.ex_rd_addr != 5'd0) &
                   ((bus.id_rs1_re & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                    (bus.id_rs2_re & (bus.id_rs2_addr == bus.ex_rd_addr)));
    end

    // Next-state logic for the bus wait-state tracker.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_hold   = 1'b0;
        unique case (state_q)
            StRun: begin
                bus_hold = bus.mem_req & ~bus.mem_ready;
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end
            end
            StMemWait: begin
                bus_hold = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TimeoutCnt) begin
                    state_d = StBusErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StBusErr: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Prioritised stall/flush decode; everything is forced low while reset is held.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        bus_err      = 1'b0;
        if (!reset) begin
            // keep defaults
        end else if (bus_hold) begin
            // Freeze everything up to MEM; branch and load-use are re-evaluated on release.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state_q == StBusErr) begin
            bus_err      = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            // The ID instruction is wrong-path, so a pending load-use is irrelevant.
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.perf_clr) begin
            stall_cnt_d = '0;
        end else if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter and performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_stall = ex_mem_stall;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.pc_redirect  = pc_redirect;
    assign bus.bus_err      = bus_err;
    assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: the driver pushes hand-computed expected
// outputs per cycle into a queue; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CntW = 4;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  ex_mem_stall, mem_wb_flush, pc_redirect, bus_err}
    localparam logic [8:0] ONone = 9'b000000000;
    localparam logic [8:0] OLu   = 9'b110010000;
    localparam logic [8:0] OBr   = 9'b001010010;
    localparam logic [8:0] OHold = 9'b110101100;
    localparam logic [8:0] OBerr = 9'b000000101;

    typedef struct {
        string           name;
        logic [8:0]      outs;
        logic [CntW-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    pipeline_hazard_ctrl_if #(.CNT_W(CntW)) hz_if ();

    pipeline_hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (CntW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.if_id_flush, hz_if.id_ex_stall,
                   hz_if.id_ex_flush, hz_if.ex_mem_stall, hz_if.mem_wb_flush,
                   hz_if.pc_redirect, hz_if.bus_err};
            checks++;
            if (act !== e.outs || hz_if.stall_count !== e.cnt) begin
                failures++;
                $display("FAIL %s: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         e.name, act, hz_if.stall_count, e.outs, e.cnt);
            end
        end
    end

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string name, input logic [8:0] outs, input int cnt);
        exp_t e;
        e.name = name;
        e.outs = outs;
        e.cnt  = CntW'(cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz_if.id_rs1_addr     = 5'd0;
        hz_if.id_rs2_addr     = 5'd0;
        hz_if.id_rs1_re       = 1'b0;
        hz_if.id_rs2_re       = 1'b0;
        hz_if.ex_rd_addr      = 5'd0;
        hz_if.ex_reg_enable   = 1'b0;
        hz_if.ex_mem_re       = 1'b0;
        hz_if.ex_branch_taken = 1'b0;
        hz_if.mem_req         = 1'b0;
        hz_if.mem_ready       = 1'b0;
        hz_if.perf_clr        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", ONone, 0);
        reset = 1'b1;

        // Load x5 in EX, ID reads rs2=x5
        hz_if.ex_mem_re = 1'b1; hz_if.ex_reg_enable = 1'b1; hz_if.ex_rd_addr = 5'd5;
        hz_if.id_rs2_addr = 5'd5; hz_if.id_rs2_re = 1'b1;
        cyc("lu_rs2", OLu, 0);
        hz_if.ex_mem_re = 1'b0;
        cyc("lu_after", ONone, 1);

        // Load to x0, ID reads x0: no hazard
        hz_if.ex_mem_re = 1'b1; hz_if.ex_rd_addr = 5'd0; hz_if.id_rs2_addr = 5'd0;
        cyc("lu_x0", ONone, 1);
        // Matching address but rs2 not read
        hz_if.ex_rd_addr = 5'd5; hz_if.id_rs2_addr = 5'd5; hz_if.id_rs2_re = 1'b0;
        cyc("lu_nore", ONone, 1);
        // Match through rs1
        hz_if.id_rs1_addr = 5'd5; hz_if.id_rs1_re = 1'b1;
        cyc("lu_rs1", OLu, 1);
        // Taken branch overrides load-use
        hz_if.ex_branch_taken = 1'b1;
        cyc("br_lu", OBr, 2);
        set_idle();
        cyc("br_after", ONone, 2);

        // Three wait states, branch pulse during the wait is ignored
        hz_if.mem_req = 1'b1;
        cyc("wait1", OHold, 2);
        hz_if.ex_branch_taken = 1'b1;
        cyc("wait2_br", OHold, 3);
        hz_if.ex_branch_taken = 1'b0;
        cyc("wait3", OHold, 4);
        hz_if.mem_ready = 1'b1;
        cyc("wait_rel", ONone, 5);
        hz_if.mem_req = 1'b0; hz_if.mem_ready = 1'b0;
        cyc("idle", ONone, 5);
        hz_if.mem_req = 1'b1; hz_if.mem_ready = 1'b1;
        cyc("zero_wait", ONone, 5);

        // Timeout with TIMEOUT=4: five held cycles then one bus_err cycle
        hz_if.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc("to_hold", OHold, 5 + i);
        hz_if.mem_req = 1'b0; hz_if.ex_branch_taken = 1'b1;
        cyc("bus_err", OBerr, 10);
        hz_if.ex_branch_taken = 1'b0;
        cyc("post_err", ONone, 10);

        // Reset while in MEM_WAIT
        hz_if.mem_req = 1'b1;
        cyc("pre_rst", OHold, 10);
        reset = 1'b0;
        cyc("rst_mid", ONone, 0);
        reset = 1'b1; hz_if.mem_ready = 1'b1;
        cyc("fresh_req", ONone, 0);
        set_idle();
        cyc("idle2", ONone, 0);

        // Hold a load-use hazard to saturate the counter
        hz_if.ex_mem_re = 1'b1; hz_if.ex_reg_enable = 1'b1; hz_if.ex_rd_addr = 5'd7;
        hz_if.id_rs2_addr = 5'd7; hz_if.id_rs2_re = 1'b1;
        for (int i = 0; i < 20; i++) cyc("sat", OLu, (i < 15) ? i : 15);
        // Clear wins over a concurrent stall
        hz_if.perf_clr = 1'b1;
        cyc("clr_lu", OLu, 15);
        set_idle();
        cyc("clr_after", ONone, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards between ID and EX, flushes wrong-path instructions on taken branches/jumps resolved in EX, and freezes the pipeline while the data bus inserts wait states.
- Drives the stall/flush inputs of every pipeline_reg bank (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Provides a bus-timeout error pulse and a stall performance counter.

Parameters:
- TIMEOUT, 16, max MEM_WAIT cycles before the data-bus access is abandoned (legal range 2..255).
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1_addr  in  5  rs1 of instruction in ID.
- id_rs2_addr  in  5  rs2 of instruction in ID.
- id_rs1_re  in  1  ID instruction reads rs1.
- id_rs2_re  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  rd of instruction in EX (ID/EX output).
- ex_reg_enable  in  1  EX instruction writes rd.
- ex_mem_re  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved taken branch/JAL/JALR.
- mem_req  in  1  MEM stage is issuing a data-bus access this cycle.
- mem_ready  in  1  data bus completes access this cycle.
- perf_clr  in  1  synchronous clear of stall_count.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  load NOP/zero into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_flush  out  1  insert bubble into MEM/WB.
- pc_redirect  out  1  select branch target for next PC.
- bus_err  out  1  one-cycle pulse on bus timeout.
- stall_count  out  CNT_W  cycles with pc_stall=1.

Behaviour:
- States: RUN, MEM_WAIT, BUS_ERR. Reset (reset=0, async): state=RUN, wait_cnt=0, stall_count=0, all 1-bit outputs 0.
- Outputs are combinational from state and current inputs; state, wait_cnt and stall_count are registered.
- load_use = ex_mem_re & ex_reg_enable & (ex_rd_addr != 0) & ((id_rs1_re & id_rs1_addr == ex_rd_addr) | (id_rs2_re & id_rs2_addr == ex_rd_addr)).
- bus_hold = mem_req & !mem_ready in RUN; !mem_ready in MEM_WAIT.
- Priority, highest first:
  - bus_hold: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush = 1; every other output 0. ex_branch_taken and load_use are ignored; they are re-evaluated after release.
  - BUS_ERR state: bus_err = 1, mem_wb_flush = 1, all stalls 0.
  - ex_branch_taken: pc_redirect, if_id_flush, id_ex_flush = 1. This overrides load_use; the ID instruction is wrong-path.
  - load_use: pc_stall, if_id_stall, id_ex_flush = 1 for exactly one cycle. The load then advances to MEM and the hazard clears with no extra state.
  - Otherwise all outputs 0.
- Transitions:
  - RUN -> MEM_WAIT when mem_req & !mem_ready; wait_cnt <= 1.
  - MEM_WAIT -> RUN when mem_ready; stalls drop in the same cycle.
  - MEM_WAIT with !mem_ready: if wait_cnt == TIMEOUT then -> BUS_ERR, else wait_cnt++.
  - BUS_ERR -> RUN unconditionally after one cycle; wait_cnt <= 0.
- mem_req=1 with mem_ready=1 in RUN is a zero-wait access: no stall, no state change.
- stall_count: perf_clr takes priority and zeroes it. Otherwise it increments when pc_stall=1 and saturates at all-ones (no wrap).
- Reset asserted mid-MEM_WAIT: immediate return to RUN; wait_cnt cleared; outputs 0 while reset is low.

Test Plan:
- Load x5 in EX (ex_mem_re=1, ex_rd_addr=5, ex_reg_enable=1), ID reads rs2=5 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0; stall_count=1.
- Same load with ex_rd_addr=0, or id_rs2_re=0 -> no stall or flush; stall_count stays 0.
- ex_branch_taken=1 together with a load_use match -> pc_redirect=if_id_flush=id_ex_flush=1 and pc_stall=0, for exactly that cycle.
- mem_req=1, mem_ready low for 3 cycles then high -> all four stalls and mem_wb_flush high for 3 cycles, released in the mem_ready cycle; a branch_taken pulse during the wait produces no redirect; stall_count=3.
- TIMEOUT=4, mem_req=1, mem_ready never asserted -> stalls for 5 cycles, then bus_err=1 for 1 cycle, then state RUN with outputs 0.
- Reset pulled low during MEM_WAIT, then released -> all outputs 0, stall_count=0; a fresh mem_req with mem_ready=1 produces no stall.
